des_round_sequencer: RTL and testbench
======================================

Name: des_round_sequencer

Overview:
Iterative DES control engine. Accepts one 64-bit block plus 64-bit key and a mode bit, and runs 16 rounds at one round per clock. It applies IP/FP and generates the key schedule (PC-1, rotations, PC-2) for both encrypt and decrypt. The round f-function (expansion, key XOR, S-boxes, P permutation) sits outside the block as a combinational chain: this block drives it each round and consumes its 32-bit result in the same cycle.

Parameters:
ROUNDS, 16, number of Feistel rounds; fixed at 16 for DES compliance and only reduced for debug builds.

Ports:
CLK  input  1  single system clock, rising edge
RESET  input  1  synchronous, active-high reset
IN_VALID  input  1  IN_DATA/IN_KEY/IN_DECRYPT valid
IN_READY  output  1  block can accept a new job
IN_DATA  input  64  plaintext or ciphertext, bit 1 = MSB (FIPS 46-3 numbering, vector [64:1])
IN_KEY  input  64  key including parity bits, [64:1]
IN_DECRYPT  input  1  0 = encrypt, 1 = decrypt
F_R_OUT  output  32  current R half to the f-function, [32:1]
F_KEY_OUT  output  48  current round subkey to the f-function, [48:1]
F_RESULT  input  32  combinational f(R,K) = P(S(E(R) xor K)) returned in the same cycle
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  downstream accepts OUT_DATA
OUT_DATA  output  64  FP(R16 || L16), [64:1]
BUSY  output  1  high in ROUND and DONE states
ROUND_NUM  output  4  current round index 0..15; 0 outside ROUND

Behaviour:
- Reset is synchronous to CLK. Outputs at reset: IN_READY=1 (state IDLE), OUT_VALID=0, OUT_DATA=0, BUSY=0, ROUND_NUM=0, F_R_OUT=0, F_KEY_OUT=0. Internal L, R, C, D and the mode register also clear to 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE
  - IN_READY=1.
  - On IN_VALID&&IN_READY: load {L,R} = IP(IN_DATA), {C,D} = PC-1(IN_KEY) (28+28 bits), latch mode, set round counter to 0, go to ROUND.
  - No other state changes.
- ROUND
  - IN_READY=0. The combinational subkey path computes the round's C',D' from registered C,D:
    - Encrypt, round i = counter+1: C',D' = rotl(C,D by s_i).
    - Decrypt, round j = counter+1: j=1 gives no rotation; j>=2 gives rotr by s_(18-j).
    - Shift table s_1..s_16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - F_KEY_OUT = PC-2(C',D'). F_R_OUT = R.
  - At the clock edge: L<=R, R<=L xor F_RESULT, C<=C', D<=D', counter++.
  - After counter==ROUNDS-1 is processed: OUT_DATA <= FP(R_new || L_new), which un-swaps the final swap. Then OUT_VALID<=1 and the state goes to DONE.
- DONE
  - OUT_VALID=1. OUT_DATA is held stable until OUT_READY is sampled high.
  - On OUT_VALID&&OUT_READY: OUT_VALID<=0, go to IDLE.
  - IN_READY=0 throughout DONE. There is no overlap of jobs.
- Latency and throughput
  - Accept edge at cycle T. ROUND occupies cycles T+1..T+16. OUT_VALID is first high in cycle T+17.
  - Minimum job-to-job interval is 18 cycles: accept at T, next accept at T+18 with OUT_READY held high.
- Combinational timing: F_RESULT must be valid in the same cycle as F_R_OUT/F_KEY_OUT. No registered path is assumed inside the f-function.
- Input stability: IN_* are ignored outside the handshake cycle and may change freely during ROUND and DONE.
- Simultaneous events: RESET wins over any handshake in the same cycle. OUT_READY high while not in DONE has no effect.
- Reset mid-operation: any state returns to IDLE on the next edge. Partial results are discarded, OUT_VALID is forced to 0 and OUT_DATA is cleared to 0.
- Counter wrap: the round counter never exceeds ROUNDS-1. In IDLE and DONE it is held at 0.

Test Plan:
1. Encrypt the FIPS vector: KEY=133457799BBCDFF1, DATA=0123456789ABCDEF, IN_DECRYPT=0 -> OUT_DATA=85E813540F0AB405, OUT_VALID rising exactly 17 cycles after the accept cycle. The bench also checks the round-1 subkey F_KEY_OUT=1B02EFFC7072.
2. Decrypt the same vector: DATA=85E813540F0AB405, same key, IN_DECRYPT=1 -> OUT_DATA=0123456789ABCDEF. The bench checks the round-1 subkey equals encrypt K16=CB3D8B0E17F5.
3. Back-pressure: hold OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_DATA stable and IN_READY=0 throughout. Release -> OUT_VALID drops the next cycle and IN_READY=1.
4. Back-to-back jobs with OUT_READY tied 1 and IN_VALID held high with new data -> second accept exactly 18 cycles after the first, and both results correct.
5. Assert RESET at ROUND_NUM=7 -> next cycle IDLE, OUT_VALID=0, OUT_DATA=0, ROUND_NUM=0. A fresh job afterwards still gives the correct result.
6. Ignored inputs: toggle IN_DATA/IN_KEY/IN_DECRYPT every cycle during ROUND -> result identical to test 1.

Source files
------------

// File: rtl/des_round_sequencer_if.sv
// rtl/des_round_sequencer_if.sv - job, f-function and result signals of the DES round sequencer
// The slave side is the sequencer; the master side is the job source, f-function and result sink.
interface des_round_sequencer_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [63:0] IN_DATA;
  logic [63:0] IN_KEY;
  logic        IN_DECRYPT;
  logic [31:0] F_R_OUT;
  logic [47:0] F_KEY_OUT;
  logic [31:0] F_RESULT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] OUT_DATA;
  logic        BUSY;
  logic [3:0]  ROUND_NUM;

  modport slave (
    input  IN_VALID, IN_DATA, IN_KEY, IN_DECRYPT, F_RESULT, OUT_READY,
    output IN_READY, F_R_OUT, F_KEY_OUT, OUT_VALID, OUT_DATA, BUSY, ROUND_NUM
  );

  modport master (
    output IN_VALID, IN_DATA, IN_KEY, IN_DECRYPT, F_RESULT, OUT_READY,
    input  IN_READY, F_R_OUT, F_KEY_OUT, OUT_VALID, OUT_DATA, BUSY, ROUND_NUM
  );
endinterface

// File: rtl/des_round_sequencer.sv
// rtl/des_round_sequencer.sv - iterative DES engine, one Feistel round per clock
// Vectors use FIPS numbering: FIPS bit n of a W-bit vector lives at index W-n.
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  des_round_sequencer_if.slave  bus
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one position, every other round by two.
  function automatic logic shift_is_two(input logic [4:0] rnd);
    return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        dec_q;

  logic [4:0]  rnd;
  logic [4:0]  rev_rnd;
  logic [27:0] c_d, d_d;
  logic [31:0] l_d, r_d;

  assign rnd     = {1'b0, cnt_q} + 5'd1;
  assign rev_rnd = 5'd18 - rnd;
  assign l_d     = r_q;
  assign r_d     = l_q ^ bus.F_RESULT;

  // Decrypt walks the encrypt schedule backwards starting from C16/D16, which equal C0/D0.
  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (!dec_q) begin
      if (shift_is_two(rnd)) begin
        c_d = {c_q[25:0], c_q[27:26]};
        d_d = {d_q[25:0], d_q[27:26]};
      end else begin
        c_d = {c_q[26:0], c_q[27]};
        d_d = {d_q[26:0], d_q[27]};
      end
    end else if (rnd != 5'd1) begin
      if (shift_is_two(rev_rnd)) begin
        c_d = {c_q[1:0], c_q[27:2]};
        d_d = {d_q[1:0], d_q[27:2]};
      end else begin
        c_d = {c_q[0], c_q[27:1]};
        d_d = {d_q[0], d_q[27:1]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.IN_VALID && in_ready_q) begin
            {l_q, r_q} <= ip_perm(bus.IN_DATA);
            {c_q, d_q} <= pc1_perm(bus.IN_KEY);
            dec_q      <= bus.IN_DECRYPT;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ROUND;
          end
        end
        ROUND: begin
          l_q <= l_d;
          r_q <= r_d;
          c_q <= c_d;
          d_q <= d_d;
          if (cnt_q == LAST_ROUND) begin
            cnt_q       <= '0;
            out_data_q  <= fp_perm({r_d, l_d});
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (out_valid_q && bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.BUSY      = busy_q;
  assign bus.ROUND_NUM = cnt_q;
  assign bus.F_R_OUT   = r_q;
  assign bus.F_KEY_OUT = pc2_perm({c_d, d_d});

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb/tb_des_round_sequencer.sv - directed bench for des_round_sequencer against FIPS 46-3 vectors
// The bench supplies the combinational f-function the sequencer drives each round.
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_round_sequencer_if bus ();

  des_round_sequencer #(.ROUNDS(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int          idx;
    x = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      idx = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      s[31-4*b -: 4] = 4'(SB[idx]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  always_comb bus.F_RESULT = des_f(bus.F_R_OUT, bus.F_KEY_OUT);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic start_job(input logic [63:0] d, input logic [63:0] k, input logic dec);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.IN_READY !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready: IN_READY=%b expected 1", bus.IN_READY);
    end
    bus.IN_DATA    = d;
    bus.IN_KEY     = k;
    bus.IN_DECRYPT = dec;
    bus.IN_VALID   = 1'b1;
    @(posedge clk);
    #1 bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_out(input int n0, output int lat);
    lat = n0;
    while (bus.OUT_VALID !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus.IN_READY); end
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.OUT_VALID); end
    n_cmp++; if (bus.OUT_DATA !== 64'h0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", bus.OUT_DATA); end
    n_cmp++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.BUSY); end
    n_cmp++; if (bus.ROUND_NUM !== 4'd0) begin n_fail++; $display("FAIL rst_round_num: got %0d expected 0", bus.ROUND_NUM); end
    n_cmp++; if (bus.F_R_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_f_r_out: got %h expected 0", bus.F_R_OUT); end
    n_cmp++; if (bus.F_KEY_OUT !== 48'h0) begin n_fail++; $display("FAIL rst_f_key_out: got %h expected 0", bus.F_KEY_OUT); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    int lat;
    bus.OUT_READY = 1'b1;
    start_job(PT, KEY, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.F_KEY_OUT !== 48'h1B02EFFC7072) begin n_fail++; $display("FAIL enc_k1: got %h expected 1b02effc7072", bus.F_KEY_OUT); end
    n_cmp++; if (bus.F_R_OUT !== 32'hF0AAF0AA) begin n_fail++; $display("FAIL enc_r0: got %h expected f0aaf0aa", bus.F_R_OUT); end
    n_cmp++; if (bus.ROUND_NUM !== 4'd0) begin n_fail++; $display("FAIL enc_round0: got %0d expected 0", bus.ROUND_NUM); end
    n_cmp++; if (bus.BUSY !== 1'b1 || bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL enc_busy: busy=%b in_ready=%b expected 1/0", bus.BUSY, bus.IN_READY); end
    @(negedge clk);
    n_cmp++; if (bus.ROUND_NUM !== 4'd1) begin n_fail++; $display("FAIL enc_round1: got %0d expected 1", bus.ROUND_NUM); end
    wait_out(2, lat);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL enc_latency: got %0d expected 17", lat); end
    n_cmp++; if (bus.OUT_DATA !== CT) begin n_fail++; $display("FAIL enc_data: got %h expected %h", bus.OUT_DATA, CT); end
    n_cmp++; if (bus.ROUND_NUM !== 4'd0 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL enc_done_state: round=%0d busy=%b expected 0/1", bus.ROUND_NUM, bus.BUSY); end
    @(negedge clk);
    n_cmp++; if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL enc_release: out_valid=%b in_ready=%b busy=%b expected 0/1/0", bus.OUT_VALID, bus.IN_READY, bus.BUSY);
    end
  endtask

  task automatic test_decrypt();
    int lat;
    bus.OUT_READY = 1'b1;
    start_job(CT, KEY, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.F_KEY_OUT !== 48'hCB3D8B0E17F5) begin n_fail++; $display("FAIL dec_k16: got %h expected cb3d8b0e17f5", bus.F_KEY_OUT); end
    wait_out(1, lat);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL dec_latency: got %0d expected 17", lat); end
    n_cmp++; if (bus.OUT_DATA !== PT) begin n_fail++; $display("FAIL dec_data: got %h expected %h", bus.OUT_DATA, PT); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] held;
    bit          ok;
    bus.OUT_READY = 1'b0;
    start_job(PT, KEY, 1'b0);
    @(negedge clk);
    wait_out(1, lat);
    held = bus.OUT_DATA;
    n_cmp++; if (held !== CT) begin n_fail++; $display("FAIL bp_data: got %h expected %h", held, CT); end
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 || bus.OUT_DATA !== held) ok = 1'b0;
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_hold: out_valid=%b in_ready=%b data=%h expected 1/0/%h", bus.OUT_VALID, bus.IN_READY, bus.OUT_DATA, held); end
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", bus.OUT_VALID, bus.IN_READY);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc, acc0, acc1, nres;
    logic [63:0] res0, res1;
    cyc  = 0;
    acc0 = -1;
    acc1 = -1;
    nres = 0;
    res0 = '0;
    res1 = '0;
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    bus.IN_DATA    = PT;
    bus.IN_KEY     = KEY;
    bus.IN_DECRYPT = 1'b0;
    bus.IN_VALID   = 1'b1;
    while (nres < 2 && cyc < 100) begin
      if (bus.IN_VALID && bus.IN_READY) begin
        if (acc0 < 0) acc0 = cyc;
        else if (acc1 < 0) acc1 = cyc;
      end
      if (bus.OUT_VALID === 1'b1) begin
        if (nres == 0) res0 = bus.OUT_DATA;
        else res1 = bus.OUT_DATA;
        nres++;
      end
      if (acc0 >= 0 && acc0 != cyc && acc1 < 0) begin
        bus.IN_DATA    = CT;
        bus.IN_DECRYPT = 1'b1;
      end
      if (acc1 >= 0 && acc1 != cyc) bus.IN_VALID = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.IN_VALID = 1'b0;
    n_cmp++; if (acc1 - acc0 !== 18) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 18", acc1 - acc0); end
    n_cmp++; if (res0 !== CT) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", res0, CT); end
    n_cmp++; if (res1 !== PT) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", res1, PT); end
  endtask

  task automatic test_mid_reset();
    int w, lat;
    bus.OUT_READY = 1'b1;
    start_job(PT, KEY, 1'b0);
    w = 0;
    @(negedge clk);
    while (bus.ROUND_NUM !== 4'd7 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++; if (bus.ROUND_NUM !== 4'd7) begin n_fail++; $display("FAIL mr_reach7: got %0d expected 7", bus.ROUND_NUM); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL mr_state: in_ready=%b out_valid=%b busy=%b expected 1/0/0", bus.IN_READY, bus.OUT_VALID, bus.BUSY);
    end
    n_cmp++; if (bus.OUT_DATA !== 64'h0) begin n_fail++; $display("FAIL mr_out_data: got %h expected 0", bus.OUT_DATA); end
    n_cmp++; if (bus.ROUND_NUM !== 4'd0) begin n_fail++; $display("FAIL mr_round_num: got %0d expected 0", bus.ROUND_NUM); end
    start_job(CT, KEY, 1'b1);
    @(negedge clk);
    wait_out(1, lat);
    n_cmp++; if (bus.OUT_DATA !== PT || lat !== 17) begin n_fail++; $display("FAIL mr_fresh_job: data=%h lat=%0d expected %h/17", bus.OUT_DATA, lat, PT); end
    @(negedge clk);
  endtask

  task automatic test_ignored_inputs();
    int lat;
    bus.OUT_READY = 1'b1;
    start_job(PT, KEY, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.OUT_VALID !== 1'b1) begin
        bus.IN_DATA    = {$urandom, $urandom};
        bus.IN_KEY     = {$urandom, $urandom};
        bus.IN_DECRYPT = 1'($urandom_range(0, 1));
      end
    end while (bus.OUT_VALID !== 1'b1 && lat < 40);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL ign_latency: got %0d expected 17", lat); end
    n_cmp++; if (bus.OUT_DATA !== CT) begin n_fail++; $display("FAIL ign_data: got %h expected %h", bus.OUT_DATA, CT); end
    @(negedge clk);
  endtask

  initial begin
    bus.IN_VALID   = 1'b0;
    bus.IN_DATA    = '0;
    bus.IN_KEY     = '0;
    bus.IN_DECRYPT = 1'b0;
    bus.OUT_READY  = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_ignored_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
